dot_accum4x4: RTL

- Downstream consumer of the 4x4 multiplier's 8-bit product `p`.
- Accumulates LEN consecutive products into one dot-product sum.
- Presents the sum on a valid/ready output port, then restarts for the next vector.
- Adds the sequencing, counting and handshaking that the combinational multiplier lacks; sits between the multiplier and the result sink.

---
 rtl/dot_accum4x4.sv | 108 ++++++++++
 1 files changed

// File: rtl/dot_accum4x4.sv
// dot_accum4x4: accumulates LEN unsigned products into one dot-product sum and
// hands it out over a valid/ready port. Define DOT_ACCUM_SAT_EN to clamp on overflow.
module dot_accum4x4 #(
   parameter int PROD_W = 8,
   parameter int ACC_W  = 12,
   parameter int LEN    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] prod,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_data,
   output logic              out_ovf
);

   localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;

   localparam logic [0:0] ST_ACCUM = 1'b0;
   localparam logic [0:0] ST_DONE  = 1'b1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);
   localparam logic [ACC_W-1:0] ACC_MAX  = {ACC_W{1'b1}};

   logic [0:0]       state_r;
   logic [ACC_W-1:0] acc_r;
   logic [CNT_W-1:0] count_r;
   logic             ovf_r;
   logic [ACC_W-1:0] out_data_r;
   logic             out_ovf_r;

   logic [ACC_W:0]   sum_s;
   logic             ovf_next_s;
   logic [ACC_W-1:0] acc_next_s;

   // Next accumulator value and sticky overflow for the product on the bus.
   always_comb begin
      sum_s      = {1'b0, acc_r} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
      ovf_next_s = ovf_r | sum_s[ACC_W];
`ifdef DOT_ACCUM_SAT_EN
      // Once overflowed, the accumulator pins at full scale for the rest of the vector.
      if (ovf_next_s) begin
         acc_next_s = ACC_MAX;
      end else begin
         acc_next_s = sum_s[ACC_W-1:0];
      end
`else
      acc_next_s = sum_s[ACC_W-1:0];
`endif
   end

   // Sequencing: accumulate in ACCUM, hold the result in DONE until the sink takes it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_ACCUM;
         acc_r      <= {ACC_W{1'b0}};
         count_r    <= {CNT_W{1'b0}};
         ovf_r      <= 1'b0;
         out_data_r <= {ACC_W{1'b0}};
         out_ovf_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_ACCUM: begin
               if (clear) begin
                  acc_r   <= {ACC_W{1'b0}};
                  count_r <= {CNT_W{1'b0}};
                  ovf_r   <= 1'b0;
               end else if (in_valid) begin
                  if (count_r == CNT_LAST) begin
                     out_data_r <= acc_next_s;
                     out_ovf_r  <= ovf_next_s;
                     state_r    <= ST_DONE;
                     acc_r      <= {ACC_W{1'b0}};
                     count_r    <= {CNT_W{1'b0}};
                     ovf_r      <= 1'b0;
                  end else begin
                     acc_r   <= acc_next_s;
                     ovf_r   <= ovf_next_s;
                     count_r <= count_r + CNT_W'(1);
                  end
               end else begin
                  acc_r <= acc_r;
               end
            end
            ST_DONE: begin
               // clear is deliberately ignored here so a finished result is never lost.
               if (out_ready) begin
                  state_r <= ST_ACCUM;
               end else begin
                  state_r <= ST_DONE;
               end
            end
            default: begin
               state_r <= ST_ACCUM;
            end
         endcase
      end
   end

   assign in_ready  = (state_r == ST_ACCUM);
   assign out_valid = (state_r == ST_DONE);
   assign out_data  = out_data_r;
   assign out_ovf   = out_ovf_r;

endmodule
